// File: rtl/mole_game_ctrl_pkg.sv
// Shared definitions for the whack-a-mole game core.
//  - state_e      : game FSM encoding (IDLE/SPAWN/UP/OVER), shared with the
//                   display and scoreboard stages
//  - MOLE_COUNT   : number of moles / LEDs / buttons
//  - LFSR_TAPS    : Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1
//  - pick_mole()  : maps LFSR bits to a mole index that never repeats the last one
package mole_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_UP    = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int          MOLE_COUNT         = 5;
  localparam int          IDX_W              = 3;
  localparam int          LFSR_W             = 16;
  localparam int          TIME_W             = 6;
  localparam int          UP_W               = 3;
  localparam logic [15:0] LFSR_TAPS          = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT  = 16'hACE1;

  // Fold the 3 random bits into 0..num-1 (one subtraction is enough because
  // 2*num > 8), then step past the previous index so a mole never relights in
  // the same hole twice in a row.
  function automatic logic [IDX_W-1:0] pick_mole(
    input logic [IDX_W-1:0] rnd,
    input logic [IDX_W-1:0] prev,
    input logic [IDX_W-1:0] num
  );
    logic [IDX_W-1:0] idx;
    idx = rnd;
    if (idx >= num) idx = idx - num;
    if (idx == prev) begin
      if (idx + IDX_W'(1) == num) idx = '0;
      else                        idx = idx + IDX_W'(1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR used as the mole randomiser.
// Ports:
//  clock  in   system clock
//  reset  in   asynchronous, active-low; loads SEED
//  q      out  current LFSR value (never zero for a nonzero SEED)
// The register advances on every clock edge while reset is deasserted.
module mole_lfsr
  import mole_game_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Right-shifting Galois form: the bit shifted out feeds back into the taps.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game core: FSM, round timer, mole escape counter and score.
// Ports:
//  clock        in   100 MHz system clock
//  reset        in   asynchronous, active-low
//  tick         in   1-cycle 1 Hz enable
//  start_pulse  in   1-cycle debounced start
//  hit_pulse    in   1-cycle debounced mole buttons, bit i = mole i
//  mole_led     out  one-hot lit mole, or 0
//  score        out  hits minus wrong presses, saturating at both ends
//  time_left    out  seconds remaining in the round
//  game_active  out  high while a round is running (SPAWN/UP)
//  game_over    out  high after the round has ended (OVER)
module mole_game_ctrl
  import mole_game_ctrl_pkg::*;
#(
  parameter int          NUM_MOLES     = MOLE_COUNT,
  parameter int          GAME_SECONDS  = 30,
  parameter int          MOLE_UP_TICKS = 2,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT,
  parameter int          SCORE_W       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start_pulse,
  input  logic [NUM_MOLES-1:0] hit_pulse,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic [SCORE_W-1:0]   score,
  output logic [TIME_W-1:0]    time_left,
  output logic                 game_active,
  output logic                 game_over
);

  state_e                 state_q, state_d;
  logic [NUM_MOLES-1:0]   mole_q,  mole_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [TIME_W-1:0]      time_q,  time_d;
  logic [IDX_W-1:0]       prev_q,  prev_d;
  logic [UP_W-1:0]        up_q,    up_d;

  logic [LFSR_W-1:0]      lfsr_value;
  logic [IDX_W-1:0]       spawn_idx;
  logic [UP_W-1:0]        up_inc;
  logic                   running;
  logic [LFSR_W-IDX_W-1:0] unused_lfsr_bits;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_value)
  );

  // Only the low bits choose the mole; the rest just keep the sequence long.
  assign unused_lfsr_bits = lfsr_value[LFSR_W-1:IDX_W];
  assign spawn_idx = pick_mole(lfsr_value[IDX_W-1:0], prev_q, IDX_W'(NUM_MOLES));
  assign up_inc    = up_q + UP_W'(1);
  assign running   = (state_q == ST_SPAWN) || (state_q == ST_UP);

  always_comb begin
    state_d = state_q;
    mole_d  = mole_q;
    score_d = score_q;
    time_d  = time_q;
    prev_d  = prev_q;
    up_d    = up_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        mole_d = '0;
        if (start_pulse) begin
          state_d = ST_SPAWN;
          time_d  = TIME_W'(GAME_SECONDS);
          score_d = '0;
        end
      end

      ST_SPAWN: begin
        mole_d  = NUM_MOLES'(1) << spawn_idx;
        prev_d  = spawn_idx;
        up_d    = '0;
        state_d = ST_UP;
      end

      ST_UP: begin
        if (hit_pulse == mole_q) begin
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          mole_d  = '0;
          state_d = ST_SPAWN;
        end else begin
          // A wrong press is penalised but does not stop the escape clock.
          if (hit_pulse != '0 && score_q != '0) score_d = score_q - SCORE_W'(1);
          if (tick) begin
            up_d = up_inc;
            if (up_inc == UP_W'(MOLE_UP_TICKS)) begin
              mole_d  = '0;
              state_d = ST_SPAWN;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Round timer runs last so expiry overrides any spawn/escape decision
    // while keeping the score update made above.
    if (running && tick) begin
      time_d = time_q - TIME_W'(1);
      if (time_q == TIME_W'(1)) begin
        state_d = ST_OVER;
        mole_d  = '0;
        prev_d  = prev_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mole_q  <= '0;
      score_q <= '0;
      time_q  <= '0;
      prev_q  <= '0;
      up_q    <= '0;
    end else begin
      state_q <= state_d;
      mole_q  <= mole_d;
      score_q <= score_d;
      time_q  <= time_d;
      prev_q  <= prev_d;
      up_q    <= up_d;
    end
  end

  assign mole_led    = mole_q;
  assign score       = score_q;
  assign time_left   = time_q;
  assign game_active = running;
  assign game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed self-checking bench for mole_game_ctrl. Expected values are pushed
// to a queue as stimulus is applied and popped when the DUT output is sampled.
module tb_mole_game_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start_pulse = 1'b0;
  logic [4:0] hit_pulse = '0;
  logic [4:0] mole_led;
  logic [7:0] score;
  logic [5:0] time_left;
  logic       game_active;
  logic       game_over;

  always #5 clock = ~clock;

  mole_game_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .start_pulse (start_pulse),
    .hit_pulse   (hit_pulse),
    .mole_led    (mole_led),
    .score       (score),
    .time_left   (time_left),
    .game_active (game_active),
    .game_over   (game_over)
  );

  // Reference LFSR: 16-bit Galois, taps 16,14,13,11, seed 16'hACE1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] n;
    n = {1'b0, x[15:1]};
    if (x[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clock or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [2:0] pick(input logic [2:0] r, input logic [2:0] p);
    logic [2:0] i;
    i = r;
    if (i >= 3'd5) i = i - 3'd5;
    if (i == p) i = (i == 3'd4) ? 3'd0 : i + 3'd1;
    return i;
  endfunction

  function automatic logic [4:0] wrong_of(input logic [4:0] led);
    return {led[3:0], led[4]};
  endfunction

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  int          tl, sc, up;
  logic [2:0]  prev;
  logic [4:0]  cur_led;
  logic [4:0]  old_led;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // Drive one cycle of inputs from a falling edge; outputs of the rising edge
  // are stable at the following falling edge where checks are made.
  task automatic step(input logic t, input logic s, input logic [4:0] h);
    tick = t;
    start_pulse = s;
    hit_pulse = h;
    @(negedge clock);
    tick = 1'b0;
    start_pulse = 1'b0;
    hit_pulse = '0;
  endtask

  // Called while the DUT sits in SPAWN: predicts the mole from the reference LFSR.
  task automatic do_spawn(input string tag);
    logic [2:0] i;
    i = pick(m_lfsr[2:0], prev);
    expect_val(32'(5'b00001 << i));
    step(1'b0, 1'b0, 5'b0);
    check(tag, 32'(mole_led));
    prev = i;
    cur_led = 5'b00001 << i;
    up = 0;
  endtask

  initial begin
    prev = 3'd0;
    sc = 0;
    up = 0;
    cur_led = '0;

    // 1) reset state and start
    repeat (3) @(negedge clock);
    expect_val(0); check("rst_mole_led", 32'(mole_led));
    expect_val(0); check("rst_score", 32'(score));
    expect_val(0); check("rst_time_left", 32'(time_left));
    expect_val(0); check("rst_game_active", 32'(game_active));
    expect_val(0); check("rst_game_over", 32'(game_over));
    reset = 1'b1;
    @(negedge clock);

    step(1'b0, 1'b1, 5'b0);
    tl = 30;
    expect_val(30); check("start_time_left", 32'(time_left));
    expect_val(1);  check("start_active", 32'(game_active));
    expect_val(0);  check("start_score", 32'(score));
    expect_val(0);  check("start_led_dark_in_spawn", 32'(mole_led));
    do_spawn("spawn_first");

    // 2) correct hit, next mole differs
    old_led = cur_led;
    step(1'b0, 1'b0, cur_led);
    sc = 1;
    expect_val(32'(sc)); check("hit_score", 32'(score));
    expect_val(0);       check("hit_led_off", 32'(mole_led));
    do_spawn("spawn_after_hit");
    expect_val(1); check("new_mole_differs", 32'(mole_led != old_led));

    // 3) wrong presses: floor at 0, multi-bit including lit one is wrong
    step(1'b0, 1'b0, wrong_of(cur_led));
    sc = 0;
    expect_val(32'(sc));      check("wrong_score_1to0", 32'(score));
    expect_val(32'(cur_led)); check("wrong_mole_stays", 32'(mole_led));
    step(1'b0, 1'b0, wrong_of(cur_led));
    expect_val(0);            check("wrong_floor", 32'(score));
    step(1'b0, 1'b0, cur_led | wrong_of(cur_led));
    expect_val(0);            check("multi_floor", 32'(score));
    expect_val(32'(cur_led)); check("multi_mole_stays", 32'(mole_led));

    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, cur_led);
      sc++;
      expect_val(32'(sc)); check("hit_run_score", 32'(score));
      do_spawn("hit_run_spawn");
    end
    step(1'b0, 1'b0, wrong_of(cur_led));
    sc--;
    expect_val(32'(sc)); check("wrong_score_3to2", 32'(score));

    // 4) escape after two ticks
    step(1'b1, 1'b0, 5'b0);
    tl--; up++;
    expect_val(32'(cur_led)); check("tick1_mole_up", 32'(mole_led));
    expect_val(32'(tl));      check("tick1_time", 32'(time_left));
    step(1'b1, 1'b0, 5'b0);
    tl--;
    expect_val(0);            check("escape_led_off", 32'(mole_led));
    expect_val(32'(sc));      check("escape_score", 32'(score));
    expect_val(32'(tl));      check("escape_time", 32'(time_left));
    do_spawn("escape_spawn");

    // wrong press with tick still advances the escape count
    step(1'b1, 1'b0, wrong_of(cur_led));
    tl--; sc--; up++;
    expect_val(32'(sc));      check("wrong_tick_score", 32'(score));
    expect_val(32'(cur_led)); check("wrong_tick_mole", 32'(mole_led));
    step(1'b1, 1'b0, 5'b0);
    tl--;
    expect_val(0);            check("wrong_tick_escape", 32'(mole_led));
    do_spawn("wrong_tick_spawn");

    // 5) run the clock down to the last second
    while (tl > 1) begin
      step(1'b1, 1'b0, 5'b0);
      tl--; up++;
      expect_val(32'(tl)); check("countdown_time", 32'(time_left));
      if (up == 2) begin
        expect_val(0); check("countdown_escape", 32'(mole_led));
        do_spawn("countdown_spawn");
      end
    end

    // 6) correct hit on the final tick scores and ends the round
    step(1'b1, 1'b0, cur_led);
    sc++;
    expect_val(32'(sc)); check("final_hit_score", 32'(score));
    expect_val(1);       check("final_game_over", 32'(game_over));
    expect_val(0);       check("final_active", 32'(game_active));
    expect_val(0);       check("final_time", 32'(time_left));
    expect_val(0);       check("final_led", 32'(mole_led));

    // hits and ticks ignored in OVER
    step(1'b1, 1'b0, 5'h1F);
    step(1'b0, 1'b0, 5'b00001);
    expect_val(32'(sc)); check("over_score_held", 32'(score));
    expect_val(0);       check("over_time_held", 32'(time_left));
    expect_val(1);       check("over_still_over", 32'(game_over));
    expect_val(0);       check("over_led_dark", 32'(mole_led));

    // restart from OVER
    step(1'b0, 1'b1, 5'b0);
    sc = 0;
    expect_val(30); check("restart_time", 32'(time_left));
    expect_val(0);  check("restart_score", 32'(score));
    expect_val(0);  check("restart_over", 32'(game_over));
    expect_val(1);  check("restart_active", 32'(game_active));
    do_spawn("restart_spawn");
    step(1'b0, 1'b0, cur_led);
    sc++;
    expect_val(32'(sc)); check("restart_hit_score", 32'(score));
    do_spawn("restart_spawn2");

    // asynchronous reset in the middle of UP, sampled between clock edges
    #2 reset = 1'b0;
    #1;
    expect_val(0); check("async_rst_led", 32'(mole_led));
    expect_val(0); check("async_rst_score", 32'(score));
    expect_val(0); check("async_rst_time", 32'(time_left));
    expect_val(0); check("async_rst_active", 32'(game_active));
    expect_val(0); check("async_rst_over", 32'(game_over));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
